seq_detect_sched: RTL and testbench

Round-robin scheduler that shares one `01110` sequence-detector instance between two requesters. Each requester hands over a `WORD_WIDTH`-bit word. The scheduler then does four things for that job:

- clears the detector;
- streams the word into it MSB-first as `{A,B}` bit pairs, one pair per clock;
- counts the `Z` pulses;
- returns the hit count, tagged with the requester id, over a valid/ready result port.

It sits between the requester fabric and the detector, which it drives directly.

---
 rtl/seq_detect_sched.sv | 130 +++++++++++++
 tb/tb_seq_detect_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin front end that time-shares one external
// 01110 sequence detector between two requesters. Each granted word is
// streamed MSB-first as {A,B} pairs. Detector hits are counted with
// saturation, and the count is returned with the owner's id.
module seq_detect_sched #(
  parameter int WORD_WIDTH = 16,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req0_valid,
  input  logic [WORD_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [WORD_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  det_clr,
  output logic                  det_a,
  output logic                  det_b,
  input  logic                  det_z,
  output logic                  done_valid,
  output logic                  done_id,
  output logic [CNT_WIDTH-1:0]  done_count,
  input  logic                  done_ready
);

  localparam int N  = WORD_WIDTH / 2;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  prio_q;    // 0: req0 wins a tie, 1: req1 wins a tie
  logic [WORD_WIDTH-1:0] sr_q;
  logic                  id_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [PW-1:0]         pair_q;    // SHIFT cycle index, 0-based
  logic                  grant0, grant1, hs, last_pair, sat;

  // Round-robin grant; ready depends combinationally on valid and the pointer
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !prio_q);
    grant1 = req1_valid && (!req0_valid ||  prio_q);
  end

  assign req0_ready = !clr && (state_q == IDLE) && grant0;
  assign req1_ready = !clr && (state_q == IDLE) && grant1;
  assign hs         = req0_ready || req1_ready;
  assign last_pair  = (pair_q == PW'(N - 1));
  assign sat        = &cnt_q;
  assign done_id    = id_q;
  assign done_count = cnt_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = CLEAR;
      CLEAR:   state_d = SHIFT;
      SHIFT:   if (last_pair) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration pointer and registered status outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      det_clr    <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      det_clr    <= (state_d != CLEAR);
      done_valid <= (state_d == DONE);
      if (state_q == DONE && done_ready) prio_q <= ~id_q;
    end
  end

  // Job datapath: capture, pair streaming and saturating hit count.
  // The pair driven during SHIFT cycle k is loaded at the edge ending the
  // previous cycle, so CLEAR preloads pair 1 and the last SHIFT cycle idles
  // the detector inputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr_q   <= '0;
      id_q   <= 1'b0;
      cnt_q  <= '0;
      pair_q <= '0;
      det_a  <= 1'b0;
      det_b  <= 1'b0;
    end else begin
      det_a <= 1'b0;
      det_b <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            sr_q  <= req1_ready ? req1_data : req0_data;
            id_q  <= req1_ready;
            cnt_q <= '0;
          end
        end
        CLEAR: begin
          pair_q <= '0;
          det_a  <= sr_q[WORD_WIDTH-1];
          det_b  <= sr_q[WORD_WIDTH-2];
          sr_q   <= sr_q << 2;
        end
        SHIFT: begin
          pair_q <= pair_q + PW'(1);
          if (!last_pair) begin
            det_a <= sr_q[WORD_WIDTH-1];
            det_b <= sr_q[WORD_WIDTH-2];
            sr_q  <= sr_q << 2;
          end
          // z seen in SHIFT cycle 1 reflects the cleared detector only
          if (pair_q != '0 && det_z && !sat) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
        DRAIN: begin
          // catches a match completed by the final pair
          if (det_z && !sat) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: a behavioural 01110 detector drives det_z,
// stimulus pushes hand-computed results into a queue, and independent
// monitors pop and compare whenever a result is handed over.
module tb_seq_detect_sched;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // DUT0: 16-bit words, 4-bit counter
  logic        r0v = 0, r1v = 0, r0r, r1r;
  logic [15:0] r0d = '0, r1d = '0;
  logic        dclr, da, db, dz, dv, did, drdy = 1;
  logic [3:0]  dcnt;

  seq_detect_sched #(.WORD_WIDTH(16), .CNT_WIDTH(4)) u0 (
    .clk(clk), .clr(clr),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
    .det_clr(dclr), .det_a(da), .det_b(db), .det_z(dz),
    .done_valid(dv), .done_id(did), .done_count(dcnt), .done_ready(drdy)
  );

  // DUT1: 32-bit words, 2-bit counter (saturation)
  logic        s0v = 0, s0r, s1r;
  logic        s1v = 0;
  logic [31:0] s0d = '0;
  logic [31:0] s1d = '0;
  logic        sclr, sa, sb, sz, sdv, sdid, sdrdy = 1;
  logic [1:0]  sdcnt;

  seq_detect_sched #(.WORD_WIDTH(32), .CNT_WIDTH(2)) u1 (
    .clk(clk), .clr(clr),
    .req0_valid(s0v), .req0_data(s0d), .req0_ready(s0r),
    .req1_valid(s1v), .req1_data(s1d), .req1_ready(s1r),
    .det_clr(sclr), .det_a(sa), .det_b(sb), .det_z(sz),
    .done_valid(sdv), .done_id(sdid), .done_count(sdcnt), .done_ready(sdrdy)
  );

  // Behavioural detectors: registered z, match may end on A or on B
  logic [3:0] h0 = '0, h1 = '0;
  int nb0 = 0, nb1 = 0;
  logic z0 = 0, z1 = 0;
  assign dz = z0;
  assign sz = z1;

  always @(posedge clk or posedge clr) begin
    if (clr || !dclr) begin
      h0 <= '0; nb0 <= 0; z0 <= 1'b0;
    end else begin
      z0 <= (nb0 >= 4 && {h0, da} == 5'b01110) || (nb0 >= 3 && {h0[2:0], da, db} == 5'b01110);
      h0 <= {h0[1:0], da, db};
      if (nb0 < 8) nb0 <= nb0 + 2;
    end
  end

  always @(posedge clk or posedge clr) begin
    if (clr || !sclr) begin
      h1 <= '0; nb1 <= 0; z1 <= 1'b0;
    end else begin
      z1 <= (nb1 >= 4 && {h1, sa} == 5'b01110) || (nb1 >= 3 && {h1[2:0], sa, sb} == 5'b01110);
      h1 <= {h1[1:0], sa, sb};
      if (nb1 < 8) nb1 <= nb1 + 2;
    end
  end

  // Scoreboard
  typedef struct packed { logic id; logic [3:0] cnt; } exp_t;
  exp_t       q0[$];
  logic [1:0] q1[$];
  int         hs0[$];
  int         hs_total = 0;
  logic       dv_prev = 0;

  // DUT0 monitor: handshakes, one-hot ready, latency, results
  always @(negedge clk) begin
    if (clr) begin
      hs0.delete();
      dv_prev <= 1'b0;
    end else begin
      if (r0r || r1r) check("ready_onehot", {r0r, r1r} == 2'b11, 0);
      if ((r0r && r0v) || (r1r && r1v)) begin
        hs0.push_back(cyc);
        hs_total++;
      end
      if (dv && !dv_prev) begin
        if (hs0.size() == 0) fail_now("latency_no_handshake");
        else check("done_latency", cyc, hs0.pop_front() + 11);
      end
      dv_prev <= dv;
      if (dv && drdy) begin
        if (q0.size() == 0) fail_now("unexpected_result");
        else begin
          exp_t e;
          e = q0.pop_front();
          check("done_id", did, e.id);
          check("done_count", dcnt, e.cnt);
        end
      end
    end
  end

  // DUT1 monitor
  always @(negedge clk) begin
    if (!clr && sdv && sdrdy) begin
      if (q1.size() == 0) fail_now("sat_unexpected_result");
      else begin
        check("sat_id", sdid, 0);
        check("sat_count", sdcnt, q1.pop_front());
      end
    end
  end

  // port 0/1: DUT0 requester, port 2: DUT1 requester 0
  task automatic send(input int port, input logic [31:0] data);
    int k;
    @(posedge clk); #1;
    case (port)
      0: begin r0v = 1; r0d = data[15:0]; end
      1: begin r1v = 1; r1d = data[15:0]; end
      default: begin s0v = 1; s0d = data; end
    endcase
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((port == 0 && r0r) || (port == 1 && r1r) || (port == 2 && s0r)) break;
    end
    if (k == 200) fail_now("send_ready");
    @(posedge clk); #1;
    r0v = 0; r1v = 0; s0v = 0;
  endtask

  task automatic wait_empty();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    if (k == 300) fail_now("scoreboard_drain");
  endtask

  logic [15:0] w;
  int target;

  initial begin
    // reset values, ready gated even with a valid request
    r0v = 1; r0d = 16'h1234;
    repeat (2) @(negedge clk);
    check("rst_det_clr", dclr, 0);
    check("rst_det_ab", {da, db}, 0);
    check("rst_done", {dv, did, dcnt}, 0);
    check("rst_ready", {r0r, r1r}, 0);
    r0v = 0;
    @(posedge clk); #1 clr = 0;
    @(negedge clk); @(negedge clk);
    check("post_rst_det_clr", dclr, 1);

    // single job with pair-level detector stream check
    w = 16'h7380;
    q0.push_back('{id: 1'b0, cnt: 4'd2});
    send(0, {16'h0, w});
    @(negedge clk);
    check("clear_pulse", dclr, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("shift_det_clr", dclr, 1);
      check("shift_pair", {da, db}, w[15 - 2*k -: 2]);
    end
    @(negedge clk);
    check("drain_pair", {da, db}, 0);
    wait_empty();

    // overlapping matches, and a match completed by the last pair
    q0.push_back('{id: 1'b1, cnt: 4'd3});
    send(1, 32'h7770);
    wait_empty();
    q0.push_back('{id: 1'b1, cnt: 4'd1});
    send(1, 32'h000E);
    wait_empty();

    // backpressure on a req1 job, then continuous arbitration
    drdy = 0;
    q0.push_back('{id: 1'b1, cnt: 4'd3});
    send(1, 32'h7770);
    begin
      int k;
      for (k = 0; k < 50; k++) begin @(negedge clk); if (dv) break; end
      if (k == 50) fail_now("bp_done_wait");
    end
    @(posedge clk); #1;
    r0v = 1; r0d = 16'h7380; r1v = 1; r1d = 16'h000E;
    q0.push_back('{id: 1'b0, cnt: 4'd2});
    q0.push_back('{id: 1'b1, cnt: 4'd1});
    q0.push_back('{id: 1'b0, cnt: 4'd2});
    q0.push_back('{id: 1'b1, cnt: 4'd1});
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", dv, 1);
      check("bp_id", did, 1);
      check("bp_count", dcnt, 3);
      check("bp_ready", {r0r, r1r}, 0);
    end
    @(posedge clk); #1 drdy = 1;
    target = hs_total + 4;
    @(negedge clk);
    @(negedge clk);
    check("idle_resume", r0r, 1);
    begin
      int k;
      for (k = 0; k < 400; k++) begin @(posedge clk); if (hs_total >= target) break; end
      if (k == 400) fail_now("arb_handshakes");
    end
    #1 r0v = 0; r1v = 0;
    wait_empty();

    // reset in the middle of SHIFT drops the job
    send(0, 32'h7770);
    repeat (7) @(negedge clk);
    #1 clr = 1;
    #1;
    check("mid_rst_det_clr", dclr, 0);
    check("mid_rst_det_ab", {da, db}, 0);
    check("mid_rst_done", {dv, did, dcnt}, 0);
    check("mid_rst_ready", {r0r, r1r}, 0);
    @(posedge clk); @(posedge clk); #1 clr = 0;
    @(negedge clk); @(negedge clk);
    check("mid_rst_release_det_clr", dclr, 1);
    @(posedge clk); #1 r1v = 1; r1d = 16'h000E;
    q0.push_back('{id: 1'b1, cnt: 4'd1});
    @(negedge clk);
    check("idle_after_reset", r1r, 1);
    @(posedge clk); #1 r1v = 0;
    wait_empty();

    // saturation on the wide instance
    q1.push_back(2'd3);
    send(2, 32'h77777777);
    wait_empty();
    q1.push_back(2'd0);
    send(2, 32'h00000000);
    wait_empty();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
